// File: rtl/config_pkg.sv
// Reduced elaborated core configuration: only the fields the descriptor reports.
// Mirrors the names of the full CVA6 config_pkg::cva6_cfg_t so callers pass the
// same structure they already build with build_config.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned CLEN;
        int unsigned VLEN;
        int unsigned PLEN;
        bit          RVA;
        bit          RVB;
        bit          RVC;
        bit          RVD;
        bit          RVF;
        bit          RVH;
        bit          RVV;
        bit          RVS;
        bit          RVU;
        bit          RVZCB;
        bit          RVZCMP;
        bit          RVZiCond;
        bit          RVZcheripurecap;
        bit          RVZcherihybrid;
        bit          CvxifEn;
        bit          FpPresent;
        bit          CheriPresent;
        bit          MmuPresent;
        bit          DebugEn;
        bit          PerfCounterEn;
        bit          UseSharedTlb;
        int unsigned NrCommitPorts;
        int unsigned NrWbPorts;
        int unsigned NR_SB_ENTRIES;
        int unsigned NrPMPEntries;
        int unsigned ICACHE_SET_ASSOC;
        int unsigned ICACHE_INDEX_WIDTH;
        int unsigned DCACHE_SET_ASSOC;
        int unsigned DCACHE_INDEX_WIDTH;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned DCACHE_LINE_WIDTH;
        int unsigned InstrTlbEntries;
        int unsigned DataTlbEntries;
        int unsigned RASDepth;
        int unsigned BTBEntries;
        int unsigned BHTEntries;
        int unsigned FETCH_WIDTH;
        int unsigned FLen;
        logic [63:0] HaltAddress;
        logic [63:0] ExceptionAddress;
        logic [63:0] DmBaseAddress;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cva6_cfg_desc_pkg.sv
// Config-descriptor format definitions: magic/version, word count, FSM states
// and the elaboration-time ROM builder that packs cva6_cfg_t into words.
// Optional feature macro: CVA6_CFG_DESC_ADDR_EN (adds six address words).
package cva6_cfg_desc_pkg;

    localparam logic [15:0] DescMagic   = 16'hCF6A;
    localparam logic [7:0]  DescVersion = 8'h01;

`ifdef CVA6_CFG_DESC_ADDR_EN
    localparam int unsigned NumWords = 15;
`else
    localparam int unsigned NumWords = 9;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CKSUM = 2'd2
    } state_e;

    // Clamp to the field width so oversized parameters read as all-ones.
    function automatic logic [7:0] sat8(input int unsigned v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [15:0] sat16(input int unsigned v);
        return (v > 32'd65535) ? 16'hFFFF : v[15:0];
    endfunction

    // Header and body words; the checksum is computed at run time.
    function automatic logic [NumWords-2:0][31:0] desc_rom(input config_pkg::cva6_cfg_t c);
        logic [NumWords-2:0][31:0] w;
        w = '0;
        w[0] = {DescMagic, DescVersion, 8'(NumWords)};
        w[1] = {sat8(c.XLEN), sat8(c.CLEN), sat8(c.VLEN), sat8(c.PLEN)};
        w[2] = {11'b0, c.UseSharedTlb, c.PerfCounterEn, c.DebugEn, c.MmuPresent,
                c.CheriPresent, c.FpPresent, c.CvxifEn, c.RVZcherihybrid,
                c.RVZcheripurecap, c.RVZiCond, c.RVZCMP, c.RVZCB, c.RVU, c.RVS,
                c.RVV, c.RVH, c.RVF, c.RVD, c.RVC, c.RVB, c.RVA};
        w[3] = {sat8(c.NrCommitPorts), sat8(c.NrWbPorts),
                sat8(c.NR_SB_ENTRIES), sat8(c.NrPMPEntries)};
        w[4] = {sat8(c.ICACHE_SET_ASSOC), sat8(c.ICACHE_INDEX_WIDTH),
                sat8(c.DCACHE_SET_ASSOC), sat8(c.DCACHE_INDEX_WIDTH)};
        w[5] = {sat16(c.ICACHE_LINE_WIDTH), sat16(c.DCACHE_LINE_WIDTH)};
        w[6] = {sat8(c.InstrTlbEntries), sat8(c.DataTlbEntries),
                sat8(c.RASDepth), sat8(c.BTBEntries)};
        w[7] = {sat16(c.BHTEntries), sat8(c.FETCH_WIDTH), sat8(c.FLen)};
`ifdef CVA6_CFG_DESC_ADDR_EN
        w[8]  = c.HaltAddress[31:0];
        w[9]  = c.HaltAddress[63:32];
        w[10] = c.ExceptionAddress[31:0];
        w[11] = c.ExceptionAddress[63:32];
        w[12] = c.DmBaseAddress[31:0];
        w[13] = c.DmBaseAddress[63:32];
`endif
        return w;
    endfunction

endpackage

// File: rtl/cva6_cfg_descriptor_tx.sv
// Serialises the elaborated core config into header, body and XOR checksum
// words on a valid/ready stream.
// Ports: clk_i, rst_i (sync, active-high); start_i/flush_i control;
//        valid_o/ready_i/data_o/last_o stream; busy_o status; done_o pulse.
// Optional feature macro: CVA6_CFG_DESC_ADDR_EN (six address words, 15 total).
module cva6_cfg_descriptor_tx
    import cva6_cfg_desc_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] data_o,
    output logic        last_o,
    output logic        done_o
);

    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam int unsigned LastBody = NumWords - 2;

    localparam logic [1:0] StIdle  = 2'(IDLE);
    localparam logic [1:0] StSend  = 2'(SEND);
    localparam logic [1:0] StCksum = 2'(CKSUM);

    localparam logic [NumWords-2:0][31:0] Rom = desc_rom(CVA6Cfg);

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [31:0]     csum_q, csum_d;
    logic            done_q, done_d;
    logic [31:0]     rom_word;
    logic            beat;

    // ROM read, compare-select so the index width need not match the ROM depth.
    always_comb begin
        rom_word = '0;
        for (int unsigned i = 0; i < NumWords - 1; i++) begin
            if (idx_q == IdxW'(i)) rom_word = Rom[i];
        end
    end

    // Outputs decode directly from the registered state.
    assign valid_o = (state_q == StSend) || (state_q == StCksum);
    assign busy_o  = valid_o;
    assign last_o  = (state_q == StCksum);
    assign data_o  = (state_q == StCksum) ? csum_q :
                     (state_q == StSend)  ? rom_word : 32'h0;
    assign done_o  = done_q;
    assign beat    = valid_o & ready_i;

    // Next-state logic; flush overrides every state including a start in IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        done_d  = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
            idx_d   = '0;
            csum_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d = StSend;
                        idx_d   = '0;
                        csum_d  = '0;
                    end
                end
                StSend: begin
                    if (beat) begin
                        csum_d = csum_q ^ rom_word;
                        idx_d  = idx_q + IdxW'(1);
                        if (idx_q == IdxW'(LastBody)) state_d = StCksum;
                    end
                end
                StCksum: begin
                    if (beat) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        csum_d  = '0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_cva6_cfg_descriptor_tx.sv
// Scoreboard bench for cva6_cfg_descriptor_tx: the stimulus process pushes the
// expected word stream per accepted start; a negedge monitor pops and compares.
module tb_cva6_cfg_descriptor_tx;

`ifdef CVA6_CFG_DESC_ADDR_EN
    localparam int NW = 15;
`else
    localparam int NW = 9;
`endif

    function automatic config_pkg::cva6_cfg_t make_cfg();
        config_pkg::cva6_cfg_t c;
        c = config_pkg::cva6_cfg_empty;
        c.XLEN = 64; c.CLEN = 128; c.VLEN = 64; c.PLEN = 56;
        c.RVA = 1; c.RVC = 1; c.RVD = 1; c.RVF = 1; c.RVS = 1; c.RVU = 1;
        c.RVZCB = 1; c.RVZiCond = 1; c.RVZcherihybrid = 1;
        c.FpPresent = 1; c.CheriPresent = 1; c.MmuPresent = 1; c.DebugEn = 1;
        c.PerfCounterEn = 1;
        c.NrCommitPorts = 2; c.NrWbPorts = 5; c.NR_SB_ENTRIES = 8; c.NrPMPEntries = 8;
        c.ICACHE_SET_ASSOC = 4; c.ICACHE_INDEX_WIDTH = 12;
        c.DCACHE_SET_ASSOC = 8; c.DCACHE_INDEX_WIDTH = 12;
        c.ICACHE_LINE_WIDTH = 128; c.DCACHE_LINE_WIDTH = 70000;
        c.InstrTlbEntries = 16; c.DataTlbEntries = 16; c.RASDepth = 2;
        c.BTBEntries = 1024; c.BHTEntries = 128; c.FETCH_WIDTH = 32; c.FLen = 64;
        c.HaltAddress = 64'h0000_0001_0000_0800;
        c.ExceptionAddress = 64'h0000_0000_0000_0808;
        c.DmBaseAddress = 64'h0;
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t TbCfg = make_cfg();

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        busy_o, valid_o, last_o, done_o;
    logic [31:0] data_o;

    cva6_cfg_descriptor_tx #(.CVA6Cfg(TbCfg)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .last_o  (last_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_words [NW];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats = 0;
    int got_done = 0;
    int want_done = 0;
    int t0 = 0;
    bit lat_check = 0;
    int ready_mode = 0;   // 0 low, 1 high, 2 toggle, 3 random
    bit prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned satv(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference words built from the format description with plain arithmetic.
    task automatic build_model();
        bit flags [21];
        int unsigned ext;
        logic [31:0] x;
        flags = '{TbCfg.RVA, TbCfg.RVB, TbCfg.RVC, TbCfg.RVD, TbCfg.RVF, TbCfg.RVH,
                  TbCfg.RVV, TbCfg.RVS, TbCfg.RVU, TbCfg.RVZCB, TbCfg.RVZCMP,
                  TbCfg.RVZiCond, TbCfg.RVZcheripurecap, TbCfg.RVZcherihybrid,
                  TbCfg.CvxifEn, TbCfg.FpPresent, TbCfg.CheriPresent,
                  TbCfg.MmuPresent, TbCfg.DebugEn, TbCfg.PerfCounterEn,
                  TbCfg.UseSharedTlb};
        ext = 0;
        for (int i = 0; i < 21; i++) if (flags[i]) ext = ext + (32'd1 << i);
        exp_words[0] = 32'hCF6A_0100 + 32'(NW);
        exp_words[1] = satv(TbCfg.XLEN, 255) * 32'h0100_0000 + satv(TbCfg.CLEN, 255) * 32'h1_0000
                     + satv(TbCfg.VLEN, 255) * 32'h100 + satv(TbCfg.PLEN, 255);
        exp_words[2] = ext;
        exp_words[3] = satv(TbCfg.NrCommitPorts, 255) * 32'h0100_0000 + satv(TbCfg.NrWbPorts, 255) * 32'h1_0000
                     + satv(TbCfg.NR_SB_ENTRIES, 255) * 32'h100 + satv(TbCfg.NrPMPEntries, 255);
        exp_words[4] = satv(TbCfg.ICACHE_SET_ASSOC, 255) * 32'h0100_0000 + satv(TbCfg.ICACHE_INDEX_WIDTH, 255) * 32'h1_0000
                     + satv(TbCfg.DCACHE_SET_ASSOC, 255) * 32'h100 + satv(TbCfg.DCACHE_INDEX_WIDTH, 255);
        exp_words[5] = satv(TbCfg.ICACHE_LINE_WIDTH, 65535) * 32'h1_0000 + satv(TbCfg.DCACHE_LINE_WIDTH, 65535);
        exp_words[6] = satv(TbCfg.InstrTlbEntries, 255) * 32'h0100_0000 + satv(TbCfg.DataTlbEntries, 255) * 32'h1_0000
                     + satv(TbCfg.RASDepth, 255) * 32'h100 + satv(TbCfg.BTBEntries, 255);
        exp_words[7] = satv(TbCfg.BHTEntries, 65535) * 32'h1_0000 + satv(TbCfg.FETCH_WIDTH, 255) * 32'h100
                     + satv(TbCfg.FLen, 255);
`ifdef CVA6_CFG_DESC_ADDR_EN
        exp_words[8]  = TbCfg.HaltAddress[31:0];
        exp_words[9]  = TbCfg.HaltAddress[63:32];
        exp_words[10] = TbCfg.ExceptionAddress[31:0];
        exp_words[11] = TbCfg.ExceptionAddress[63:32];
        exp_words[12] = TbCfg.DmBaseAddress[31:0];
        exp_words[13] = TbCfg.DmBaseAddress[63:32];
`endif
        x = '0;
        for (int i = 0; i < NW - 1; i++) x = x ^ exp_words[i];
        exp_words[NW-1] = x;
    endtask

    // Ready pattern, updated after the stimulus process so mode changes land deterministically.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: ready_i = 1'b0;
            1: ready_i = 1'b1;
            2: ready_i = ~ready_i;
            default: ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard pops on each counted beat, stall stability, done legality.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i) begin
            if (prev_stall) chk("stall_hold", {31'b0, valid_o, last_o, data_o}, {31'b0, 1'b1, prev_last, prev_data});
            if (valid_o && ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {32'b0, data_o}, 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", {32'b0, data_o}, {32'b0, e.data});
                    chk("beat_last", {63'b0, last_o}, {63'b0, e.last});
                end
                beats++;
            end
            if (done_o) begin
                chk("done_pending", 64'(got_done < want_done), 64'd1);
                if (lat_check) chk("done_latency", 64'(cyc - t0), 64'(NW + 1));
                got_done++;
            end
        end
        prev_stall = !rst_i && !flush_i && valid_o && !ready_i;
        prev_data  = data_o;
        prev_last  = last_o;
    end

    task automatic push_txn();
        exp_t e;
        for (int i = 0; i < NW; i++) begin
            e.data = exp_words[i];
            e.last = (i == NW - 1);
            exp_q.push_back(e);
        end
        want_done++;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start_i = 1'b1;
        t0 = cyc;
        push_txn();
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (got_done < want_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 64'(want_done - got_done), 64'd0);
        @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_beats(input int nb, input int budget);
        int base = beats;
        int n = 0;
        while (beats - base < nb && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("beat_timeout", 64'(beats - base), 64'(nb));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        build_model();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'b0, valid_o, busy_o, last_o, done_o, data_o}, 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {27'b0, valid_o, busy_o, last_o, done_o, data_o}, 64'd0);

        // Full-rate transfer with latency checks.
        ready_mode = 1;
        lat_check = 1;
        do_start();
        @(negedge clk);
        chk("first_word_valid", {63'b0, valid_o}, 64'd1);
        wait_done(40);
        lat_check = 0;

        // Alternating ready.
        ready_mode = 2;
        do_start();
        wait_done(60);

        // Flush after four beats: no done, then clean restart.
        ready_mode = 1;
        do_start();
        wait_beats(4, 20);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        exp_q.delete();
        want_done = got_done;
        @(negedge clk);
        chk("flush_idle", {62'b0, valid_o, busy_o}, 64'd0);
        repeat (15) @(negedge clk);
        chk("flush_no_done", 64'(got_done), 64'(want_done));
        do_start();
        wait_done(40);

        // Start and flush together in IDLE: flush wins.
        @(posedge clk); #1;
        start_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        chk("start_flush_idle", {62'b0, valid_o, busy_o}, 64'd0);

        // Starts during SEND and CKSUM are ignored.
        ready_mode = 2;
        do_start();
        wait_beats(2, 20);
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        begin
            int n = 0;
            while (!(last_o && !ready_i) && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("reach_cksum_stall", {63'b0, last_o}, 64'd1);
        end
        @(posedge clk); #1;
        ready_mode = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        ready_mode = 2;
        wait_done(40);
        repeat (12) @(negedge clk);
        chk("single_done", 64'(got_done), 64'(want_done));

        // Reset in the middle of SEND.
        ready_mode = 1;
        do_start();
        wait_beats(3, 20);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        want_done = got_done;
        @(negedge clk);
        chk("midsend_reset", {27'b0, valid_o, busy_o, last_o, done_o, data_o}, 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {27'b0, valid_o, busy_o, last_o, done_o, data_o}, 64'd0);

        // Randomised ready pressure.
        ready_mode = 3;
        for (int t = 0; t < 4; t++) begin
            do_start();
            wait_done(200);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
